// File: rtl/rad_async_fifo_wptr_full.sv
// Write-domain pointer and flag stage of the rad async FIFO: binary/Gray write pointer,
// full, almost-full, level and overflow, all registered in the write clock domain.
module rad_async_fifo_wptr_full #(
  parameter int unsigned ADDRSIZE     = 3,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam logic [ADDRSIZE:0] AfullLvl = AFULL_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wgray_d;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] level_d;
  logic [ADDRSIZE:0] full_cmp;
  logic              accept;

  logic [ADDRSIZE:0] wptr_q;
  logic              wfull_q, afull_q, ovf_q;
  logic [ADDRSIZE:0] level_q;

  always_comb begin
    accept   = winc & ~wfull_q;
    wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, accept};
    wgray_d  = (wbin_d >> 1) ^ wbin_d;
    // Full when the write pointer is exactly one lap ahead of the read pointer.
    full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
  end

  always_comb begin
    rbin           = '0;
    rbin[ADDRSIZE] = wq2_rptr[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ wq2_rptr[i];
    end
    level_d = wbin_d - rbin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wgray_d;
      wfull_q <= (wgray_d == full_cmp);
      afull_q <= (level_d >= AfullLvl);
      level_q <= level_d;
      ovf_q   <= winc & wfull_q;
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = afull_q;
  assign wlevel       = level_q;
  assign woverflow    = ovf_q;

endmodule
